shake256_absorb_packer: RTL and testbench

- Front end that feeds the SHAKE256 core's message side. It accepts a message as a byte stream with a valid/ready handshake.
- Packs bytes into 1088-bit rate blocks, applies the SHAKE256 domain suffix and pad10*1 padding, and presents full blocks to the core with a block valid/ready handshake.
- Sits between a message source (UART/switch loader) and SHAKE256.message/length.

---
 rtl/shake256_absorb_packer.sv | 106 ++++++++++
 tb/tb_shake256_absorb_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shake256_absorb_packer.sv
// Packs a byte stream into SHAKE256 rate blocks with domain suffix and pad10*1 padding.
// Latency: block offered the cycle after its final byte; one bubble per block; in_ready low while a block is held.
module shake256_absorb_packer #(
    parameter int         RATE_BYTES = 136,
    parameter logic [7:0] SUFFIX     = 8'h1F
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_keep,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [8*RATE_BYTES-1:0]   block,
    output logic [10:0]               block_len,
    output logic                      block_last,
    output logic                      block_valid,
    input  logic                      block_ready
);
    localparam int              CW       = $clog2(RATE_BYTES + 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(RATE_BYTES);
    localparam logic [10:0]     FULL_LEN = 11'(8 * RATE_BYTES);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                         r_state, w_state_nxt;
    logic [CW-1:0]                  r_cnt, w_cnt_nxt, w_cnt_after;
    logic [RATE_BYTES-1:0][7:0]     r_buf, w_buf_nxt;
    logic                           r_pend_pad, w_pend_nxt;
    logic [10:0]                    r_len, w_len_nxt;
    logic                           r_last, w_last_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf;
        w_pend_nxt  = r_pend_pad;
        w_len_nxt   = r_len;
        w_last_nxt  = r_last;
        w_cnt_after = in_keep ? r_cnt + 1'b1 : r_cnt;
        case (r_state)
            FILL: begin
                if (in_valid) begin
                    if (in_keep)
                        w_buf_nxt[r_cnt] = in_data;
                    w_cnt_nxt = w_cnt_after;
                    if (in_keep && w_cnt_after == FULL_CNT) begin
                        // A message ending exactly on a block boundary still owes a pad-only block.
                        w_state_nxt = HOLD;
                        w_len_nxt   = FULL_LEN;
                        w_last_nxt  = 1'b0;
                        w_pend_nxt  = in_last;
                    end else if (in_last) begin
                        // When these land on the same byte the XORs combine to 8'h9F.
                        w_buf_nxt[w_cnt_after]    = w_buf_nxt[w_cnt_after] ^ SUFFIX;
                        w_buf_nxt[RATE_BYTES-1]   = w_buf_nxt[RATE_BYTES-1] ^ 8'h80;
                        w_state_nxt = HOLD;
                        w_len_nxt   = 11'(w_cnt_after) << 3;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (block_ready) begin
                    if (r_pend_pad) begin
                        w_buf_nxt               = '0;
                        w_buf_nxt[0]            = SUFFIX;
                        w_buf_nxt[RATE_BYTES-1] = 8'h80;
                        w_len_nxt               = 11'd0;
                        w_last_nxt              = 1'b1;
                        w_pend_nxt              = 1'b0;
                    end else begin
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = FILL;
                    end
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_pend_pad <= 1'b0;
            r_len      <= 11'd0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_buf      <= w_buf_nxt;
            r_pend_pad <= w_pend_nxt;
            r_len      <= w_len_nxt;
            r_last     <= w_last_nxt;
        end
    end

    assign in_ready    = (r_state == FILL);
    assign block_valid = (r_state == HOLD);
    assign block       = r_buf;
    assign block_len   = r_len;
    assign block_last  = r_last;
endmodule

// File: tb/tb_shake256_absorb_packer.sv
// Bench for shake256_absorb_packer: reference sponge padding model feeding a block scoreboard.
module tb_shake256_absorb_packer;
    localparam int RB = 136;

    logic            clock = 1'b0;
    logic            reset;
    logic [7:0]      in_data;
    logic            in_keep, in_last, in_valid, in_ready;
    logic [8*RB-1:0] block;
    logic [10:0]     block_len;
    logic            block_last, block_valid, block_ready;

    shake256_absorb_packer #(.RATE_BYTES(RB), .SUFFIX(8'h1F)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .block(block), .block_len(block_len), .block_last(block_last),
        .block_valid(block_valid), .block_ready(block_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8*RB-1:0] blk;
        logic [10:0]     len;
        logic            last;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         n_blk  = 0;
    logic [7:0] stall_msg[$];
    bit         drv_done;

    // Reference sponge padding: full blocks, then a final block holding the remainder (possibly empty).
    function automatic void push_expected(input logic [7:0] msg[$]);
        exp_t e;
        int   n = msg.size();
        int   nfull = n / RB;
        int   r = n % RB;
        for (int b = 0; b < nfull; b++) begin
            e.blk = '0;
            for (int j = 0; j < RB; j++) e.blk[8*j +: 8] = msg[b*RB + j];
            e.len = 11'(8*RB);
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        e.blk = '0;
        for (int j = 0; j < r; j++) e.blk[8*j +: 8] = msg[nfull*RB + j];
        e.blk[8*r +: 8]      = e.blk[8*r +: 8] ^ 8'h1F;
        e.blk[8*(RB-1) +: 8] = e.blk[8*(RB-1) +: 8] ^ 8'h80;
        e.len  = 11'(8*r);
        e.last = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Scoreboard: compare each block at the moment the core accepts it.
    always @(negedge clock) begin
        if (reset === 1'b1 && block_valid === 1'b1 && block_ready === 1'b1) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_block #%0d: got len=%0d last=%0b, required none", n_blk, block_len, block_last);
            end else begin
                e = exp_q.pop_front();
                if (block !== e.blk) begin
                    int k = 0;
                    while (k < RB-1 && block[8*k +: 8] === e.blk[8*k +: 8]) k++;
                    n_fail++;
                    $display("FAIL block_data #%0d byte %0d: got %h required %h", n_blk, k, block[8*k +: 8], e.blk[8*k +: 8]);
                end
                n_vec++;
                if (block_len !== e.len) begin
                    n_fail++;
                    $display("FAIL block_len #%0d: got %0d required %0d", n_blk, block_len, e.len);
                end
                n_vec++;
                if (block_last !== e.last) begin
                    n_fail++;
                    $display("FAIL block_last #%0d: got %0b required %0b", n_blk, block_last, e.last);
                end
            end
            n_blk++;
        end
    end

    task automatic drive_beat(input logic [7:0] d, input logic k, input logic l);
        int t = 0;
        @(negedge clock);
        in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 2000) begin
            n_vec++; n_fail++;
            $display("FAIL beat_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clock);
        #1 in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit bubbles);
        if (msg.size() == 0) drive_beat(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < msg.size(); i++) begin
            if (bubbles && (i % 7 == 3)) drive_beat(8'h5A, 1'b0, 1'b0);
            drive_beat(msg[i], 1'b1, i == msg.size() - 1);
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (!(exp_q.size() == 0 && block_valid === 1'b0 && in_ready === 1'b1) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        n_vec++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL %s_drain: %0d blocks outstanding, block_valid=%b, required 0 and 0", name, exp_q.size(), block_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_vec++; if (block_valid !== 1'b0) begin n_fail++; $display("FAIL reset_block_valid: got %b required 0", block_valid); end
        n_vec++; if (block_len !== 11'd0)  begin n_fail++; $display("FAIL reset_block_len: got %0d required 0", block_len); end
        n_vec++; if (block_last !== 1'b0)  begin n_fail++; $display("FAIL reset_block_last: got %b required 0", block_last); end
        reset = 1'b1;
    endtask

    task automatic test_empty();
        logic [7:0] m[$];
        push_expected(m);
        send_msg(m, 0);
        wait_drain("empty");
    endtask

    task automatic test_abc(input string name);
        logic [7:0] m[$];
        m = '{8'h61, 8'h62, 8'h63};
        push_expected(m);
        send_msg(m, 0);
        n_vec++; if (block_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency_valid: got %b required 1", name, block_valid); end
        n_vec++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL %s_latency_ready: got %b required 0", name, in_ready); end
        wait_drain(name);
    endtask

    task automatic test_len(input int n, input bit bubbles, input string name);
        logic [7:0] m[$];
        for (int i = 0; i < n; i++) m.push_back((n == 135) ? 8'hAA : 8'(i * 13 + n));
        push_expected(m);
        send_msg(m, bubbles);
        wait_drain(name);
    endtask

    task automatic test_stall_300();
        logic [8*RB-1:0] cap;
        int t = 0;
        stall_msg.delete();
        for (int i = 0; i < 300; i++) stall_msg.push_back(8'(i * 7 + 3));
        push_expected(stall_msg);
        @(posedge clock); #1 block_ready = 1'b0;
        drv_done = 1'b0;
        fork
            begin send_msg(stall_msg, 0); drv_done = 1'b1; end
        join_none
        while (block_valid !== 1'b1 && t < 1000) begin @(negedge clock); t++; end
        n_vec++;
        if (t >= 1000) begin n_fail++; $display("FAIL stall_first_block: block_valid got %b required 1", block_valid); end
        cap = block;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_vec++; if (block !== cap)        begin n_fail++; $display("FAIL stall_block_stable cycle %0d: block changed", c); end
            n_vec++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b required 0", c, in_ready); end
            n_vec++; if (block_valid !== 1'b1) begin n_fail++; $display("FAIL stall_block_valid cycle %0d: got %b required 1", c, block_valid); end
        end
        @(posedge clock); #1 block_ready = 1'b1;
        t = 0;
        while (!drv_done && t < 3000) begin @(negedge clock); t++; end
        n_vec++;
        if (!drv_done) begin n_fail++; $display("FAIL stall_driver: done=%b required 1", drv_done); end
        wait_drain("stall300");
    endtask

    task automatic test_reset_midfill();
        for (int i = 0; i < 50; i++) drive_beat(8'(i + 8'hC0), 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_vec++; if (block !== '0)         begin n_fail++; $display("FAIL midreset_buffer: got nonzero required zero"); end
        n_vec++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL midreset_in_ready: got %b required 1", in_ready); end
        n_vec++; if (block_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_block_valid: got %b required 0", block_valid); end
        reset = 1'b1;
        test_abc("abc_after_reset");
    endtask

    initial begin
        in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0; in_valid = 1'b0;
        block_ready = 1'b1; reset = 1'b0; drv_done = 1'b0;
        test_reset();
        test_empty();
        test_abc("abc");
        test_len(135, 0, "len135");
        test_len(136, 0, "len136");
        test_len(100, 1, "bubbles100");
        test_stall_300();
        test_reset_midfill();
        test_len(272, 0, "back_to_back_272");
        test_len(1, 0, "back_to_back_1");
        test_len(137, 0, "len137");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end
endmodule
